// File: rtl/acc_arb_pkg.sv
// Shared definitions for the accumulator arbiter: opcodes, FSM encoding, core bound.
// ACC_ARB_FIXED_PRIO_EN (rr_arbiter / acc_arbiter) selects fixed-priority arbitration.
package acc_arb_pkg;

    localparam int MAX_CORES = 8;

    typedef logic [1:0] op_t;

    localparam op_t OP_READ = 2'b00;
    localparam op_t OP_LOAD = 2'b01;
    localparam op_t OP_INC  = 2'b10;
    localparam op_t OP_CLR  = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/acc_arb_if.sv
// Core-side request/response bus plus the shared accumulator strobes and readback.
interface acc_arb_if #(
    parameter int NUM_CORES  = 4,
    parameter int DATA_WIDTH = 16
);
    logic [NUM_CORES-1:0]            req;
    logic [2*NUM_CORES-1:0]          op;
    logic [NUM_CORES*DATA_WIDTH-1:0] wdata;
    logic [NUM_CORES-1:0]            gnt;
    logic [NUM_CORES-1:0]            done;
    logic [DATA_WIDTH-1:0]           rdata;
    logic                            z_out;
    logic                            acc_we;
    logic                            acc_inc;
    logic                            acc_clr;
    logic [DATA_WIDTH-1:0]           acc_data_in;
    logic [DATA_WIDTH-1:0]           acc_data_out;
    logic                            acc_z;

    modport master (
        output req, op, wdata, acc_data_out, acc_z,
        input  gnt, done, rdata, z_out, acc_we, acc_inc, acc_clr, acc_data_in
    );

    modport slave (
        input  req, op, wdata, acc_data_out, acc_z,
        output gnt, done, rdata, z_out, acc_we, acc_inc, acc_clr, acc_data_in
    );
endinterface

// File: rtl/acc_arbiter_rr_arbiter.sv
// Combinational requester pick: first set req at or after the pointer, wrapping.
// With ACC_ARB_FIXED_PRIO_EN defined the pointer port is absent and index 0 has top priority.
module rr_arbiter
    import acc_arb_pkg::*;
#(
    parameter  int NUM_CORES = 4,
    localparam int PTR_W     = ptr_width(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] i_req,
`ifndef ACC_ARB_FIXED_PRIO_EN
    input  logic [PTR_W-1:0]     i_ptr,
`endif
    output logic [NUM_CORES-1:0] o_gnt,
    output logic [PTR_W-1:0]     o_idx,
    output logic                 o_any
);

    logic [PTR_W-1:0] w_idx;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_idx = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
`ifdef ACC_ARB_FIXED_PRIO_EN
            w_idx = PTR_W'(k);
`else
            w_idx = PTR_W'((int'(i_ptr) + k) % NUM_CORES);
`endif
            if (!o_any && i_req[w_idx]) begin
                o_any        = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_idx        = w_idx;
            end
        end
    end

endmodule

// File: rtl/acc_arbiter.sv
// Shares one accumulator among NUM_CORES cores: grant, one-cycle strobe, settle, respond.
// ACC_ARB_FIXED_PRIO_EN replaces round-robin with lowest-index-wins priority.
module acc_arbiter
    import acc_arb_pkg::*;
#(
    parameter int NUM_CORES  = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    acc_arb_if.slave arb_bus
);

    localparam int PTR_W = ptr_width(NUM_CORES);

    logic [1:0]            r_state;
    logic [NUM_CORES-1:0]  r_gnt;
    logic [NUM_CORES-1:0]  r_done;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_z_out;
    logic                  r_acc_we;
    logic                  r_acc_inc;
    logic                  r_acc_clr;
    logic [DATA_WIDTH-1:0] r_acc_data_in;
`ifndef ACC_ARB_FIXED_PRIO_EN
    logic [PTR_W-1:0]      r_ptr;
    logic [PTR_W-1:0]      r_win;
`endif

    logic [NUM_CORES-1:0]  w_pick;
    logic [PTR_W-1:0]      w_pick_idx;
    logic                  w_pick_any;
    op_t                   w_op_arr    [NUM_CORES];
    logic [DATA_WIDTH-1:0] w_wdata_arr [NUM_CORES];
    op_t                   w_pick_op;
    logic [DATA_WIDTH-1:0] w_pick_wdata;

    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_unpack
        assign w_op_arr[gi]    = arb_bus.op[2*gi+1:2*gi];
        assign w_wdata_arr[gi] = arb_bus.wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_pick_op    = w_op_arr[w_pick_idx];
    assign w_pick_wdata = w_wdata_arr[w_pick_idx];

    rr_arbiter #(.NUM_CORES(NUM_CORES)) u_pick (
        .i_req (arb_bus.req),
`ifndef ACC_ARB_FIXED_PRIO_EN
        .i_ptr (r_ptr),
`endif
        .o_gnt (w_pick),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    // Strobes are registered at grant so they are high for exactly the ISSUE cycle
    // and drop the instant reset asserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_gnt         <= '0;
            r_done        <= '0;
            r_rdata       <= '0;
            r_z_out       <= 1'b0;
            r_acc_we      <= 1'b0;
            r_acc_inc     <= 1'b0;
            r_acc_clr     <= 1'b0;
            r_acc_data_in <= '0;
`ifndef ACC_ARB_FIXED_PRIO_EN
            r_ptr         <= '0;
            r_win         <= '0;
`endif
        end else begin
            r_done    <= '0;
            r_acc_we  <= 1'b0;
            r_acc_inc <= 1'b0;
            r_acc_clr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_any) begin
                        r_gnt     <= w_pick;
                        r_acc_we  <= (w_pick_op == OP_LOAD);
                        r_acc_inc <= (w_pick_op == OP_INC);
                        r_acc_clr <= (w_pick_op == OP_CLR);
                        if (w_pick_op == OP_LOAD) begin
                            r_acc_data_in <= w_pick_wdata;
                        end
`ifndef ACC_ARB_FIXED_PRIO_EN
                        r_win     <= w_pick_idx;
`endif
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE:  r_state <= ST_SETTLE;
                ST_SETTLE: r_state <= ST_RESP;
                ST_RESP: begin
                    r_rdata <= arb_bus.acc_data_out;
                    r_z_out <= arb_bus.acc_z;
                    r_done  <= r_gnt;
                    r_gnt   <= '0;
`ifndef ACC_ARB_FIXED_PRIO_EN
                    r_ptr   <= (r_win == PTR_W'(NUM_CORES - 1)) ? '0 : r_win + 1'b1;
`endif
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign arb_bus.gnt         = r_gnt;
    assign arb_bus.done        = r_done;
    assign arb_bus.rdata       = r_rdata;
    assign arb_bus.z_out       = r_z_out;
    assign arb_bus.acc_we      = r_acc_we;
    assign arb_bus.acc_inc     = r_acc_inc;
    assign arb_bus.acc_clr     = r_acc_clr;
    assign arb_bus.acc_data_in = r_acc_data_in;

endmodule

// File: tb/tb_acc_arbiter.sv
// Scoreboard bench for acc_arbiter with a behavioural accumulator (no reset, lagging z flag).
// Honours ACC_ARB_FIXED_PRIO_EN for the all-requesting grant order.
module tb_acc_arbiter;
    import acc_arb_pkg::*;

    localparam int NC = 4;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cycle = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    acc_arb_if #(.NUM_CORES(NC), .DATA_WIDTH(DW)) bus ();

    acc_arbiter #(.NUM_CORES(NC), .DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .arb_bus (bus)
    );

    logic          core_req [NC];
    op_t           core_op  [NC];
    logic [DW-1:0] core_wd  [NC];

    for (genvar gi = 0; gi < NC; gi++) begin : g_pack
        assign bus.req[gi]            = core_req[gi];
        assign bus.op[2*gi+1:2*gi]    = core_op[gi];
        assign bus.wdata[gi*DW +: DW] = core_wd[gi];
    end

    // Accumulator: data updates on the strobe edge, z follows one edge later.
    logic [DW-1:0] acc_val = 16'h1234;
    logic          acc_z_reg = 1'b0;
    always @(posedge clk) begin
        if (bus.acc_we)       acc_val <= bus.acc_data_in;
        else if (bus.acc_inc) acc_val <= acc_val + 1'b1;
        else if (bus.acc_clr) acc_val <= '0;
        acc_z_reg <= ($signed(acc_val) <= 0);
    end
    assign bus.acc_data_out = acc_val;
    assign bus.acc_z        = acc_z_reg;

    typedef struct {
        int            core;
        op_t           op;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic          z;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, want, cycle);
        end
    endtask

    function automatic logic [2:0] exp_strobe(input op_t op);
        case (op)
            OP_LOAD: return 3'b100;
            OP_INC:  return 3'b010;
            OP_CLR:  return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [NC-1:0] onehot(input int core);
        return NC'(1 << core);
    endfunction

    // Monitor: checks grant/strobe at the first ISSUE cycle and the response at done.
    logic [NC-1:0] prev_gnt = '0;
    int            gnt_cycle = 0;
    exp_t          mon_e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.gnt != '0 && prev_gnt == '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_gnt", 64'(bus.gnt), 64'(0));
                end else begin
                    mon_e = exp_q[0];
                    gnt_cycle = cycle;
                    check("gnt_onehot", 64'(bus.gnt), 64'(onehot(mon_e.core)));
                    check("issue_strobe", 64'({bus.acc_we, bus.acc_inc, bus.acc_clr}),
                          64'(exp_strobe(mon_e.op)));
                    if (mon_e.op == OP_LOAD)
                        check("acc_data_in", 64'(bus.acc_data_in), 64'(mon_e.wdata));
                end
            end else if ({bus.acc_we, bus.acc_inc, bus.acc_clr} != 3'b000) begin
                check("stray_strobe", 64'({bus.acc_we, bus.acc_inc, bus.acc_clr}), 64'(0));
            end
            if (bus.done != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'(bus.done), 64'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("done_onehot", 64'(bus.done), 64'(onehot(mon_e.core)));
                    check("rdata", 64'(bus.rdata), 64'(mon_e.rdata));
                    check("z_out", 64'(bus.z_out), 64'(mon_e.z));
                    check("latency", 64'(cycle - gnt_cycle), 64'(3));
                    $display("txn core=%0d op=%0b rdata=%h z=%0b at cycle %0d",
                             mon_e.core, mon_e.op, bus.rdata, bus.z_out, cycle);
                end
            end
        end
        prev_gnt = bus.gnt;
    end

    task automatic push_exp(input int core, input op_t op, input logic [DW-1:0] wd,
                            input logic [DW-1:0] r, input logic z);
        exp_t e;
        e.core = core; e.op = op; e.wdata = wd; e.rdata = r; e.z = z;
        exp_q.push_back(e);
    endtask

    task automatic do_txn(input int core, input op_t op, input logic [DW-1:0] wd,
                          input logic [DW-1:0] exp_r, input logic exp_z, input bit drop_early);
        bit got = 0;
        push_exp(core, op, wd, exp_r, exp_z);
        @(negedge clk);
        core_req[core] = 1'b1;
        core_op[core]  = op;
        core_wd[core]  = wd;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (drop_early && (bus.gnt & onehot(core)) != '0) begin
                core_req[core] = 1'b0;
                core_op[core]  = OP_INC;
                core_wd[core]  = 16'hAAAA;
            end
            if ((bus.done & onehot(core)) != '0) got = 1;
        end
        if (!got) check("done_timeout", 64'(bus.done), 64'(onehot(core)));
        core_req[core] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int last;
        bit hit;
        for (int i = 0; i < NC; i++) begin
            core_req[i] = 1'b0;
            core_op[i]  = OP_READ;
            core_wd[i]  = '0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset: every output and strobe stays at zero.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_outputs", {bus.gnt, bus.done, bus.rdata, bus.z_out,
                  bus.acc_we, bus.acc_inc, bus.acc_clr, bus.acc_data_in}, 64'(0));
        end

        do_txn(1, OP_LOAD, 16'h0005, 16'h0005, 1'b0, 0);
        do_txn(0, OP_CLR,  16'h0000, 16'h0000, 1'b1, 0);
        do_txn(0, OP_READ, 16'h0000, 16'h0000, 1'b1, 0);
        do_txn(2, OP_INC,  16'h0000, 16'h0001, 1'b0, 0);

        repeat (3) @(negedge clk);
        check("rdata_hold", 64'({bus.rdata, bus.z_out}), 64'({16'h0001, 1'b0}));

        // Pointer now at 3; a core3 read moves it back to 0.
        do_txn(3, OP_READ, 16'h0000, 16'h0001, 1'b0, 0);

        // All four requesting continuously.
`ifdef ACC_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 5; i++) push_exp(0, OP_READ, '0, 16'h0001, 1'b0);
`else
        for (int i = 0; i < 5; i++) push_exp(i % NC, OP_READ, '0, 16'h0001, 1'b0);
`endif
        @(negedge clk);
        for (int i = 0; i < NC; i++) begin
            core_req[i] = 1'b1;
            core_op[i]  = OP_READ;
        end
        seen = 0;
        last = 0;
        for (int i = 0; i < 60 && seen < 5; i++) begin
            @(negedge clk);
            if (bus.done != '0) begin
                if (seen > 0) check("rr_gap", 64'(cycle - last), 64'(4));
                last = cycle;
                seen++;
                if (seen == 5)
                    for (int k = 0; k < NC; k++) core_req[k] = 1'b0;
            end
        end
        if (seen < 5) check("rr_count", 64'(seen), 64'(5));
        for (int k = 0; k < NC; k++) core_req[k] = 1'b0;

        do_txn(2, OP_LOAD, 16'hFFFF, 16'hFFFF, 1'b1, 0);
        do_txn(1, OP_INC,  16'h0000, 16'h0000, 1'b1, 0);

        // Reset while core3's inc is in ISSUE.
        push_exp(3, OP_INC, '0, 16'h0001, 1'b0);
        @(negedge clk);
        core_req[3] = 1'b1;
        core_op[3]  = OP_INC;
        hit = 0;
        for (int i = 0; i < 10 && !hit; i++) begin
            @(negedge clk);
            if (bus.acc_inc) hit = 1;
        end
        check("reset_issue_seen", 64'(hit), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("reset_strobes", 64'({bus.acc_we, bus.acc_inc, bus.acc_clr}), 64'(0));
        check("reset_gnt", 64'(bus.gnt), 64'(0));
        exp_q.delete();
        core_req[3] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("reset_rdata", 64'({bus.rdata, bus.z_out, bus.done}), 64'(0));

        do_txn(3, OP_INC,  16'h0000, 16'h0001, 1'b0, 0);
        do_txn(0, OP_LOAD, 16'h0007, 16'h0007, 1'b0, 1);

        repeat (4) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
